// File: rtl/trace_capture.sv
// Circular-buffer trace recorder: samples a bus once armed, stops a programmable
// number of samples after a masked trigger, then streams the window oldest-first.
module trace_capture #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             arm,
    input  logic             abort,
    input  logic [WIDTH-1:0] sample_in,
    input  logic [WIDTH-1:0] trig_value,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [AW-1:0]    post_len,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,
    output logic [AW-1:0]    trig_index,
    output logic             ovf,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        POST    = 2'd2,
        READOUT = 2'd3
    } state_t;

    localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_F    = 1;
    localparam logic [AW-1:0] ONE_A    = 1;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    remaining;
    logic [AW-1:0]    post_len_q;
    logic [AW-1:0]    fill_m1;
    logic [AW-1:0]    window_post;
    logic [AW:0]      fill;
    logic [AW:0]      fill_inc;
    logic [AW:0]      cnt;
    logic             match;
    logic             writing;
    logic             xfer;
    logic             to_readout;

    assign match       = ((sample_in ^ trig_value) & trig_mask) == '0;
    assign writing     = (state_q == ARMED || state_q == POST) && !abort;
    assign fill_inc    = (fill == FILL_MAX) ? fill : fill + ONE_F;
    assign fill_m1     = AW'(fill_inc - ONE_F);
    assign window_post = (state_q == POST) ? post_len_q : post_len;

    // Reset and abort both suppress the handshake in the cycle they are seen,
    // so a consumer never takes a word from a capture that is being discarded.
    assign rd_valid = (state_q == READOUT) && !abort && RST;
    assign rd_last  = rd_valid && (cnt == ONE_F);
    assign rd_data  = mem[rd_ptr];
    assign xfer     = rd_valid && rd_ready;
    assign state    = state_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        to_readout = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) state_d = ARMED;
            end
            ARMED: begin
                if (match) begin
                    if (post_len == '0) begin
                        state_d    = READOUT;
                        to_readout = 1'b1;
                    end else begin
                        state_d = POST;
                    end
                end
            end
            POST: begin
                if (remaining == ONE_A) begin
                    state_d    = READOUT;
                    to_readout = 1'b1;
                end
            end
            READOUT: begin
                if (xfer && rd_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d    = IDLE;
            to_readout = 1'b0;
        end
    end

    // Sample storage is never cleared; fill and the pointers decide what is read.
    always_ff @(posedge CLK) begin
        if (RST && writing) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            cnt        <= '0;
            remaining  <= '0;
            post_len_q <= '0;
            trig_index <= '0;
            ovf        <= 1'b0;
        end else begin
            if (state_q == IDLE && arm && !abort) begin
                wr_ptr <= '0;
                fill   <= '0;
                ovf    <= 1'b0;
            end
            if (writing) begin
                wr_ptr <= wr_ptr + ONE_A;
                fill   <= fill_inc;
                if (fill == FILL_MAX) ovf <= 1'b1;
            end
            if (state_q == ARMED && match) begin
                remaining  <= post_len;
                post_len_q <= post_len;
            end
            if (state_q == POST) begin
                remaining <= remaining - ONE_A;
            end
            // Once wrapped, the oldest surviving sample sits where the next write would go.
            if (to_readout) begin
                rd_ptr     <= (fill_inc == FILL_MAX) ? wr_ptr + ONE_A : '0;
                cnt        <= fill_inc;
                trig_index <= fill_m1 - window_post;
            end
            if (xfer) begin
                rd_ptr <= rd_ptr + ONE_A;
                cnt    <= cnt - ONE_F;
            end
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: expected read words go into a scoreboard
// queue and an independent monitor pops and compares them on every transfer.
module tb_trace_capture;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    logic             CLK;
    logic             RST;
    logic             arm;
    logic             abort;
    logic [WIDTH-1:0] sample_in;
    logic [WIDTH-1:0] trig_value;
    logic [WIDTH-1:0] trig_mask;
    logic [AW-1:0]    post_len;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_last;
    logic [AW-1:0]    trig_index;
    logic             ovf;
    logic [1:0]       state;

    int               vectors;
    int               miscompares;
    exp_t             sb[$];
    logic [WIDTH-1:0] stim[$];
    logic             hold_pending;
    logic [WIDTH-1:0] held_data;
    logic             held_last;
    logic [7:0]       ready_pat;

    trace_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .arm        (arm),
        .abort      (abort),
        .sample_in  (sample_in),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
        .post_len   (post_len),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .trig_index (trig_index),
        .ovf        (ovf),
        .state      (state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushRange(input logic [31:0] lo, input logic [31:0] hi);
        for (logic [31:0] v = lo; v <= hi; v++) begin
            sb.push_back('{data: v, last: (v == hi)});
        end
    endtask

    task automatic fillStim(input logic [31:0] lo, input logic [31:0] hi);
        stim.delete();
        for (logic [31:0] v = lo; v <= hi; v++) stim.push_back(v);
    endtask

    // Arms the recorder and feeds every queued sample, one per cycle.
    task automatic applyStimulus(input logic [31:0] tv, input logic [31:0] tm, input logic [AW-1:0] pl);
        @(posedge CLK); #1;
        trig_value = tv;
        trig_mask  = tm;
        post_len   = pl;
        arm        = 1'b1;
        @(posedge CLK); #1;
        arm = 1'b0;
        foreach (stim[i]) begin
            sample_in = stim[i];
            @(posedge CLK); #1;
        end
    endtask

    task automatic checkReadoutEntry(input string tag, input logic [AW-1:0] exp_ti, input logic exp_ovf);
        checkOutput({tag, "_state"}, 32'(state), 32'd3);
        checkOutput({tag, "_valid"}, 32'(rd_valid), 32'd1);
        checkOutput({tag, "_trig_index"}, 32'(trig_index), 32'(exp_ti));
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    endtask

    task automatic drainReadout(input string tag, input bit bp, input bit arm_mid);
        int i;
        i = 0;
        while (i < 300 && !(sb.size() == 0 && state == 2'd0)) begin
            if (bp) rd_ready = ready_pat[i % 8];
            if (arm_mid) arm = (i == 0);
            @(posedge CLK); #1;
            i++;
        end
        arm      = 1'b0;
        rd_ready = 1'b1;
        checkOutput({tag, "_drained"}, 32'(sb.size()), 32'd0);
        checkOutput({tag, "_idle"}, 32'(state), 32'd0);
        checkOutput({tag, "_valid_low"}, 32'(rd_valid), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every accepted word and checks that a
    // stalled word stays put until it is taken.
    always @(negedge CLK) begin
        exp_t e;
        if (hold_pending) begin
            checkOutput("hold_valid", 32'(rd_valid), 32'd1);
            checkOutput("hold_data", rd_data, held_data);
            checkOutput("hold_last", 32'(rd_last), 32'(held_last));
        end
        hold_pending = rd_valid && !rd_ready;
        held_data    = rd_data;
        held_last    = rd_last;
        if (rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_word: got %0h, expected no transfer", rd_data);
            end else begin
                e = sb.pop_front();
                checkOutput("rd_data", rd_data, e.data);
                checkOutput("rd_last", 32'(rd_last), 32'(e.last));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit saw_valid;
        vectors      = 0;
        miscompares  = 0;
        hold_pending = 1'b0;
        ready_pat    = 8'b0110_1001;
        RST          = 1'b0;
        arm          = 1'b0;
        abort        = 1'b0;
        sample_in    = '0;
        trig_value   = '0;
        trig_mask    = '0;
        post_len     = '0;
        rd_ready     = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_valid", 32'(rd_valid), 32'd0);
        checkOutput("rst_last", 32'(rd_last), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_trig_index", 32'(trig_index), 32'd0);

        $display("[TB] basic capture, trigger 5, post 3");
        fillStim(1, 8);
        pushRange(1, 8);
        applyStimulus(32'd5, '1, 4'd3);
        checkReadoutEntry("basic", 4'd4, 1'b0);
        drainReadout("basic", 1'b0, 1'b0);

        $display("[TB] wrapped capture, trigger 30, post 4");
        fillStim(1, 34);
        pushRange(19, 34);
        applyStimulus(32'd30, '1, 4'd4);
        checkReadoutEntry("wrap", 4'd11, 1'b1);
        drainReadout("wrap", 1'b0, 1'b0);

        $display("[TB] masked trigger");
        stim.delete();
        stim.push_back(32'h0000_0007);
        stim.push_back(32'h08AB_CDE7);
        sb.push_back('{data: 32'h0000_0007, last: 1'b0});
        sb.push_back('{data: 32'h08AB_CDE7, last: 1'b1});
        applyStimulus(32'h0800_0007, 32'hFF00_000F, 4'd0);
        checkReadoutEntry("mask", 4'd1, 1'b0);
        drainReadout("mask", 1'b0, 1'b0);

        $display("[TB] backpressure readout");
        fillStim(101, 106);
        pushRange(101, 106);
        applyStimulus(32'd104, '1, 4'd2);
        checkReadoutEntry("bp", 4'd3, 1'b0);
        drainReadout("bp", 1'b1, 1'b0);

        $display("[TB] reset during readout");
        fillStim(1, 8);
        sb.push_back('{data: 32'd1, last: 1'b0});
        sb.push_back('{data: 32'd2, last: 1'b0});
        sb.push_back('{data: 32'd3, last: 1'b0});
        applyStimulus(32'd5, '1, 4'd3);
        checkReadoutEntry("rstmid", 4'd4, 1'b0);
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(posedge CLK); #1;
        end
        checkOutput("rstmid_three_words", 32'(sb.size()), 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        checkOutput("rstmid_state", 32'(state), 32'd0);
        checkOutput("rstmid_valid", 32'(rd_valid), 32'd0);
        checkOutput("rstmid_ovf", 32'(ovf), 32'd0);
        fillStim(201, 204);
        pushRange(201, 204);
        applyStimulus(32'd202, '1, 4'd2);
        checkReadoutEntry("fresh", 4'd1, 1'b0);
        drainReadout("fresh", 1'b0, 1'b0);

        $display("[TB] abort during POST");
        fillStim(1, 4);
        applyStimulus(32'd3, '1, 4'd5);
        checkOutput("abort_in_post", 32'(state), 32'd2);
        abort = 1'b1;
        @(posedge CLK); #1;
        abort = 1'b0;
        checkOutput("abort_state", 32'(state), 32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            saw_valid |= rd_valid;
            @(posedge CLK); #1;
        end
        checkOutput("abort_no_valid", 32'(saw_valid), 32'd0);

        $display("[TB] arm during READOUT");
        fillStim(11, 14);
        pushRange(11, 14);
        applyStimulus(32'd12, '1, 4'd2);
        checkReadoutEntry("armro", 4'd1, 1'b0);
        drainReadout("armro", 1'b0, 1'b1);

        $display("[TB] zero mask, post 2");
        fillStim(50, 52);
        pushRange(50, 52);
        applyStimulus(32'hDEAD_BEEF, 32'h0, 4'd2);
        checkReadoutEntry("mask0", 4'd0, 1'b0);
        drainReadout("mask0", 1'b0, 1'b0);

        $display("[TB] arm and abort together");
        @(posedge CLK); #1;
        arm   = 1'b1;
        abort = 1'b1;
        @(posedge CLK); #1;
        arm   = 1'b0;
        abort = 1'b0;
        checkOutput("arm_abort_state", 32'(state), 32'd0);

        repeat (2) @(posedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Synthesizable trace recorder; the capture/read-back counterpart of the formal trace replay benches, which inject a recorded trace into a UUT.
- Samples a WIDTH-bit observed bus every cycle into a circular buffer once armed, and stops after a masked-value trigger plus a programmable post-trigger window.
- Streams the captured window out oldest-first over a valid/ready port, so counterexample traces can be pulled out of a running design.

Parameters:
WIDTH, 32, sample and read-data width
DEPTH, 16, buffer entries; power of two, >= 4
AW, $clog2(DEPTH), address width (derived, do not override)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous reset, active-low
arm  in  1  start-capture pulse; honoured only in IDLE
abort  in  1  return to IDLE from any state; overrides arm
sample_in  in  WIDTH  observed bus
trig_value  in  WIDTH  trigger compare value
trig_mask  in  WIDTH  1 = bit participates in compare
post_len  in  AW  samples captured after the trigger sample; sampled at trigger
rd_valid  out  1  read word available
rd_ready  in  1  consumer accepts word
rd_data  out  WIDTH  captured sample
rd_last  out  1  final word of window, qualified by rd_valid
trig_index  out  AW  readout position of the trigger sample; valid in READOUT
ovf  out  1  buffer wrapped, so earliest samples were lost; valid in READOUT
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 READOUT

Behaviour:
- Reset (RST==0 at a rising edge):
  - state=IDLE; rd_valid, rd_last, ovf, trig_index = 0; wr_ptr, fill, remaining = 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards the capture, and no further handshake occurs.
- Match condition: ((sample_in ^ trig_value) & trig_mask) == 0. mask=0 matches on the first ARMED cycle.
- IDLE:
  - arm=1 -> ARMED; clear wr_ptr, fill, ovf.
  - No sample is written on the arm cycle.
- ARMED, each cycle:
  - mem[wr_ptr] <= sample_in; wr_ptr <= wr_ptr+1, wrapping mod DEPTH.
  - fill increments, saturating at DEPTH; ovf <= 1 on any write while fill==DEPTH.
  - On match, the written sample is the trigger sample; latch post_len into remaining.
  - If post_len==0 -> READOUT, else -> POST.
- POST, each cycle:
  - Write exactly as in ARMED; the match condition is ignored.
  - remaining decrements; when it reaches 0 -> READOUT.
  - The window is always exactly post_len samples after the trigger sample.
- Entering READOUT:
  - rd_ptr = (fill==DEPTH) ? wr_ptr : 0.
  - cnt = fill.
  - trig_index = fill-1-post_len_latched.
- READOUT:
  - rd_valid=1; rd_data = mem[rd_ptr] (combinational read of register array).
  - rd_last = (cnt==1).
  - On rd_valid & rd_ready: rd_ptr++ (wrapping), cnt--.
  - On the transfer with rd_last=1 -> IDLE, and rd_valid drops the next cycle.
  - While rd_ready=0, rd_data and rd_last are held stable.
- arm is ignored outside IDLE.
- abort=1 in any state -> IDLE next cycle; rd_valid=0 from that cycle; a pending word is not transferred.
- abort and arm in the same IDLE cycle: remain IDLE.
- Simultaneous trigger and wrap: the write and the ovf update happen normally; trig_index formula still holds.
- One sample per cycle, no gaps.
- Latency from trigger sample to first rd_valid: post_len+1 cycles.

Test Plan:
- DEPTH=16; arm; sample_in=1,2,3,... per ARMED cycle; trig_value=5, mask=all-ones, post_len=3 -> exactly 8 reads 1..8 with rd_ready=1; rd_last only on 8; trig_index=4; ovf=0; state returns to IDLE.
- Same, trig_value=30, post_len=4 -> 34 samples written; reads 19..34 (16 words); ovf=1; trig_index=11 (word value 30).
- Masked trigger:
  - trig_value=32'h0800_0007, mask=32'hFF00_000F, post_len=0.
  - Feed 32'h0000_0007, then 32'h08AB_CDE7.
  - Expected: 2 reads, the second 32'h08AB_CDE7 with rd_last=1; trig_index=1.
- Backpressure: in READOUT drive rd_ready 1,0,0,1,0,1... -> no word lost or duplicated; rd_data and rd_last stable during every rd_ready=0 cycle; word order unchanged.
- Reset mid-readout:
  - Drive RST=0 for one cycle after the 3rd word.
  - Expected: next cycle state=0, rd_valid=0, ovf=0.
  - A fresh arm/capture then reads back only new samples.
- Control corner cases:
  - abort during POST -> IDLE, no rd_valid.
  - arm during READOUT -> ignored, readout completes.
  - mask=0 -> trigger on the first ARMED sample; with post_len=2, 3 reads and trig_index=0.
